// File: rtl/ssd_scan_driver.sv
// Two-digit multiplexed seven-segment driver: calculator-style digit shift-in,
// chip_sel scanning and a blanking gap after every digit switch to avoid ghosting.
module ssd_scan_driver #(
  parameter int clk_freq       = 50_000_000,
  parameter int refresh_hz     = 1000,
  parameter int blank_cycles   = 16,
  parameter bit seg_active_low = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       clear,
  output logic [6:0] seg,
  output logic       chip_sel,
  output logic       frame_tick
);

  localparam int refresh_div = clk_freq / refresh_hz;
  localparam int cw = (refresh_div > 1) ? $clog2(refresh_div) : 1;
  localparam int bw = (blank_cycles > 0) ? $clog2(blank_cycles + 1) : 1;
  localparam logic [cw-1:0] refresh_last = cw'(refresh_div - 1);
  localparam logic [bw-1:0] blank_load   = bw'(blank_cycles);

  typedef enum logic {SHOW, BLANK} phase_t;

  phase_t          state, state_next;
  logic [cw-1:0]   refresh_cnt;
  logic [bw-1:0]   blank_cnt, blank_cnt_next;
  logic [3:0]      d0, d1, d0_next, d1_next;
  logic            blank0, blank1, blank0_next, blank1_next;
  logic            terminal, chip_sel_next;
  logic [3:0]      sel_digit;
  logic            sel_blank;
  logic [6:0]      seg_lit, seg_next;

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'b0111111;
      4'h1: font = 7'b0000110;
      4'h2: font = 7'b1011011;
      4'h3: font = 7'b1001111;
      4'h4: font = 7'b1100110;
      4'h5: font = 7'b1101101;
      4'h6: font = 7'b1111101;
      4'h7: font = 7'b0000111;
      4'h8: font = 7'b1111111;
      4'h9: font = 7'b1101111;
      4'hA: font = 7'b1110111;
      4'hB: font = 7'b1111100;
      4'hC: font = 7'b0111001;
      4'hD: font = 7'b1011110;
      4'hE: font = 7'b1111001;
      default: font = 7'b1110001;
    endcase
  endfunction

  // Segment data is built from the next-cycle digit values so a strobe shows up
  // on seg in the very next cycle despite seg being registered.
  always_comb begin
    d0_next        = d0;
    d1_next        = d1;
    blank0_next    = blank0;
    blank1_next    = blank1;
    chip_sel_next  = chip_sel;
    blank_cnt_next = blank_cnt;
    state_next     = state;
    terminal       = (refresh_cnt == refresh_last);

    if (clear) begin
      d0_next     = 4'h0;
      d1_next     = 4'h0;
      blank0_next = 1'b1;
      blank1_next = 1'b1;
    end else if (digit_valid) begin
      d1_next     = d0;
      blank1_next = blank0;
      d0_next     = digit_in;
      blank0_next = 1'b0;
    end

    if (terminal) begin
      chip_sel_next  = ~chip_sel;
      blank_cnt_next = blank_load;
    end else if (blank_cnt != '0) begin
      blank_cnt_next = blank_cnt - 1'b1;
    end
    state_next = (blank_cnt_next != '0) ? BLANK : SHOW;

    sel_digit = chip_sel_next ? d1_next : d0_next;
    sel_blank = chip_sel_next ? blank1_next : blank0_next;
    seg_next  = (state_next == SHOW && !sel_blank) ? font(sel_digit) : 7'b0000000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SHOW;
      refresh_cnt <= '0;
      blank_cnt   <= '0;
      chip_sel    <= 1'b0;
      frame_tick  <= 1'b0;
      seg_lit     <= 7'b0000000;
      d0          <= 4'h0;
      d1          <= 4'h0;
      blank0      <= 1'b1;
      blank1      <= 1'b1;
    end else begin
      state       <= state_next;
      refresh_cnt <= terminal ? '0 : refresh_cnt + 1'b1;
      blank_cnt   <= blank_cnt_next;
      chip_sel    <= chip_sel_next;
      frame_tick  <= terminal && chip_sel;
      seg_lit     <= seg_next;
      d0          <= d0_next;
      d1          <= d1_next;
      blank0      <= blank0_next;
      blank1      <= blank1_next;
    end
  end

  assign seg = seg_active_low ? ~seg_lit : seg_lit;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed and random strobes compared each cycle against
// a model that derives scan position and blanking from the cycle count since reset.
module tb_ssd_scan_driver;

  logic       clk = 1'b0;
  logic       rst, digit_valid, clear;
  logic [3:0] digit_in;
  logic [6:0] seg_hi, seg_lo;
  logic       cs_hi, cs_lo, ft_hi, ft_lo;

  int assertions = 0;
  int failures   = 0;

  int         n;
  logic [3:0] m_d0, m_d1;
  bit         m_b0, m_b1;
  logic [6:0] font_tbl [16];

  always #5 clk = ~clk;

  ssd_scan_driver #(.clk_freq(1000), .refresh_hz(100), .blank_cycles(2), .seg_active_low(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit_in(digit_in), .clear(clear),
    .seg(seg_hi), .chip_sel(cs_hi), .frame_tick(ft_hi)
  );

  ssd_scan_driver #(.clk_freq(1000), .refresh_hz(100), .blank_cycles(2), .seg_active_low(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit_in(digit_in), .clear(clear),
    .seg(seg_lo), .chip_sel(cs_lo), .frame_tick(ft_lo)
  );

  task automatic check_output();
    logic       exp_cs, exp_ft, gap, dblank;
    logic [3:0] dval;
    logic [6:0] exp_seg;
    exp_cs  = ((n / 10) % 2) == 1;
    gap     = (n >= 10) && ((n % 10) < 2);
    exp_ft  = (n >= 10) && ((n % 10) == 0) && !exp_cs;
    dval    = exp_cs ? m_d1 : m_d0;
    dblank  = exp_cs ? m_b1 : m_b0;
    exp_seg = (gap || dblank) ? 7'b0000000 : font_tbl[dval];

    assertions++;
    assert (seg_hi === exp_seg) else begin
      failures++;
      $error("[TB] FAIL seg n=%0d observed=%b expected=%b", n, seg_hi, exp_seg);
    end
    assertions++;
    assert (seg_lo === ~exp_seg) else begin
      failures++;
      $error("[TB] FAIL seg_active_low n=%0d observed=%b expected=%b", n, seg_lo, ~exp_seg);
    end
    assertions++;
    assert (cs_hi === exp_cs && cs_lo === exp_cs) else begin
      failures++;
      $error("[TB] FAIL chip_sel n=%0d observed=%b/%b expected=%b", n, cs_hi, cs_lo, exp_cs);
    end
    assertions++;
    assert (ft_hi === exp_ft && ft_lo === exp_ft) else begin
      failures++;
      $error("[TB] FAIL frame_tick n=%0d observed=%b/%b expected=%b", n, ft_hi, ft_lo, exp_ft);
    end
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, check 1ns later.
  task automatic apply_stimulus(input bit r, input bit dv, input logic [3:0] din, input bit cl);
    @(negedge clk);
    rst = r; digit_valid = dv; digit_in = din; clear = cl;
    @(posedge clk);
    if (r) begin
      n = 0; m_d0 = 0; m_d1 = 0; m_b0 = 1; m_b1 = 1;
    end else begin
      n++;
      if (cl) begin
        m_d0 = 0; m_d1 = 0; m_b0 = 1; m_b1 = 1;
      end else if (dv) begin
        m_d1 = m_d0; m_b1 = m_b0; m_d0 = din; m_b0 = 0;
      end
    end
    #1 check_output();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    font_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                 7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
    rst = 1'b1; digit_valid = 1'b0; digit_in = 4'h0; clear = 1'b0;
    n = 0; m_d0 = 0; m_d1 = 0; m_b0 = 1; m_b1 = 1;

    apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
    idle(40);

    apply_stimulus(1'b0, 1'b1, 4'h3, 1'b0);
    idle(25);

    apply_stimulus(1'b0, 1'b1, 4'h7, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'hA, 1'b0);
    idle(25);

    // Strobe inside a digit0 display window, away from the blanking gap.
    for (int i = 0; i < 30 && !(((n / 10) % 2) == 0 && (n % 10) >= 3 && (n % 10) <= 6); i++)
      idle(1);
    apply_stimulus(1'b0, 1'b1, 4'h5, 1'b0);
    idle(5);

    apply_stimulus(1'b0, 1'b1, 4'h8, 1'b1);
    idle(22);
    apply_stimulus(1'b0, 1'b1, 4'h1, 1'b0);
    idle(22);

    apply_stimulus(1'b0, 1'b1, 4'h9, 1'b0);
    idle(13);
    apply_stimulus(1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    apply_stimulus(1'b0, 1'b1, 4'h3, 1'b0);
    idle(22);

    apply_stimulus(1'b0, 1'b1, 4'hF, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'hE, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'hD, 1'b0);
    idle(22);

    for (int i = 0; i < 600; i++)
      apply_stimulus($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                     4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
